branch_predictor: RTL

- Fetch-stage direction predictor and target buffer for the RV32 core.
- Fetch asks it, one cycle ahead, whether a conditional branch at the fetch PC will be taken and where it will go.
- The execute-stage branch comparator later resolves the branch; that outcome returns on the update port, which trains the predictor and flags mispredictions.
- Combinational lookup, clocked training, one update per cycle.

---
 rtl/branch_predictor.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch direction predictor and target buffer (direct-mapped, 2-bit counters).
// Latency: lookup is combinational (zero cycles); training and the mispredict counter update on the next rising edge.
// Backpressure: none. One lookup and one update are accepted every cycle, and a lookup never sees a same-cycle update.
module branch_predictor #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Table storage. Only valid and the counter are reset; tag and target are
  // meaningless while valid is clear.
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];

  logic [INDEX_W-1:0] pred_idx;
  logic [TAG_W-1:0]   pred_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic [1:0]         ctr_next;

  // Word-offset bits of the update addresses carry no information here.
  logic unused_low_bits;
  assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

  assign pred_idx = pred_pc[INDEX_W+1:2];
  assign pred_tag = pred_pc[31:INDEX_W+2];
  assign upd_idx  = upd_pc[INDEX_W+1:2];
  assign upd_tag  = upd_pc[31:INDEX_W+2];

  // Lookup path: reads only registered table state, so a same-cycle update
  // to the same entry is not visible until the following cycle.
  always_comb begin
    pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
    pred_taken  = pred_hit && ctr_q[pred_idx][1];
    pred_target = pred_taken ? {tgt_q[pred_idx], 2'b00} : (pred_pc + 32'd4);
  end

  // Redirect request: wrong direction, or right (taken) direction with wrong target.
  always_comb begin
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
  end

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ctr_next = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'b01;
    end
  end

  // Valid bits and counters: reset wins; hits train, taken misses allocate weakly-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target: every taken outcome writes them (on a hit the tag is unchanged).
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target[31:2];
    end
  end

  // Misprediction counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_count <= 32'd0;
    end else if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule
